cv32e40x_bpred_seq: RTL and testbench

Sequencer and arbiter for the branch target/prediction array that feeds the `hit_i`/`prediction_i` path into the controller. It shares the single-port array between IF lookups and EX branch-resolution updates, buffering updates in a small FIFO. It applies 2-bit saturating counter arithmetic and walks the whole array to invalidate it after reset or on a flush request (fence.i / `cache_cmd` invalidate).

---
 rtl/cv32e40x_bpred_seq_if.sv | 27 ++
 rtl/cv32e40x_bpred_seq.sv | 84 ++++++++
 tb/tb_cv32e40x_bpred_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_bpred_seq_if.sv
// cv32e40x_bpred_seq_if: lookup, update, flush and array-write signals of the prediction array sequencer
interface cv32e40x_bpred_seq_if #(parameter int IDX_W = 4);
  logic             lookup_req_i;
  logic [IDX_W-1:0] lookup_idx_i;
  logic             lookup_gnt_o;
  logic             upd_valid_i;
  logic             upd_ready_o;
  logic [IDX_W-1:0] upd_idx_i;
  logic             upd_hit_i;
  logic [1:0]       upd_ctr_i;
  logic             upd_taken_i;
  logic             flush_req_i;
  logic             flush_ack_o;
  logic             arr_we_o;
  logic [IDX_W-1:0] arr_widx_o;
  logic             arr_wvalid_o;
  logic [1:0]       arr_wctr_o;
  logic             busy_o;
  modport master (
    output lookup_req_i, lookup_idx_i, upd_valid_i, upd_idx_i, upd_hit_i, upd_ctr_i, upd_taken_i, flush_req_i,
    input  lookup_gnt_o, upd_ready_o, flush_ack_o, arr_we_o, arr_widx_o, arr_wvalid_o, arr_wctr_o, busy_o
  );
  modport slave (
    input  lookup_req_i, lookup_idx_i, upd_valid_i, upd_idx_i, upd_hit_i, upd_ctr_i, upd_taken_i, flush_req_i,
    output lookup_gnt_o, upd_ready_o, flush_ack_o, arr_we_o, arr_widx_o, arr_wvalid_o, arr_wctr_o, busy_o
  );
endinterface

// File: rtl/cv32e40x_bpred_seq.sv
// cv32e40x_bpred_seq: single-port prediction array arbiter with update FIFO and invalidate walk (optional CV32E40X_BPRED_ALLOC_EN)
module cv32e40x_bpred_seq #(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES),
  parameter int UPD_DEPTH   = 2
) (
  input logic                clk,
  input logic                rst,
  cv32e40x_bpred_seq_if.slave bus
);
`ifdef CV32E40X_BPRED_ALLOC_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif
  localparam int CW = $clog2(UPD_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BTB_ENTRIES - 1);
  typedef enum logic [1:0] {INIT, IDLE, FLUSH} state_e;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [1:0]       ctr;
    logic             taken;
  } upd_t;
  state_e           state_q, state_d;
  logic [IDX_W-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  upd_t             fifo_q [UPD_DEPTH];
  upd_t             fifo_d [UPD_DEPTH];
  upd_t             head;
  logic             full, walk, head_win, push;
  // port arbitration and array write data
  always_comb begin
    head     = fifo_q[0];
    full     = cnt_q == CW'(UPD_DEPTH);
    walk     = state_q != IDLE;
    head_win = state_q == IDLE && !bus.flush_req_i && cnt_q != '0 && (full || !bus.lookup_req_i);
    push     = state_q == IDLE && !bus.flush_req_i && bus.upd_valid_i && !full;
    bus.busy_o       = walk;
    bus.lookup_gnt_o = state_q == IDLE && !bus.flush_req_i && bus.lookup_req_i && !full;
    bus.upd_ready_o  = state_q == FLUSH || (state_q == IDLE && !full);
    bus.flush_ack_o  = wcnt_q == LAST && (state_q == FLUSH || (state_q == INIT && bus.flush_req_i));
    bus.arr_we_o     = walk || (head_win && (head.hit || (ALLOC && head.taken)));
    bus.arr_widx_o   = walk ? wcnt_q : head.idx;
    bus.arr_wvalid_o = !walk;
    bus.arr_wctr_o   = walk ? 2'b00 : !head.hit ? 2'b10 :
                       head.taken ? (head.ctr == 2'b11 ? 2'b11 : head.ctr + 2'b01) :
                                    (head.ctr == 2'b00 ? 2'b00 : head.ctr - 2'b01);
  end
  // walk counter, state transitions and FIFO push/pop; a flush drops queued and incoming updates
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
    fifo_d  = fifo_q;
    if (walk) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LAST) state_d = IDLE;
    end else if (bus.flush_req_i) begin
      state_d = FLUSH;
      wcnt_d  = '0;
      cnt_d   = '0;
    end else begin
      if (head_win) for (int i = 0; i < UPD_DEPTH - 1; i++) fifo_d[i] = fifo_q[i+1];
      for (int i = 0; i < UPD_DEPTH; i++)
        if (push && i == int'(cnt_q) - int'(head_win))
          fifo_d[i] = {bus.upd_idx_i, bus.upd_hit_i, bus.upd_ctr_i, bus.upd_taken_i};
      cnt_d = cnt_q + CW'(push) - CW'(head_win);
    end
  end
  // state registers; FIFO payload needs no reset since occupancy gates its use
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
    if (rst) begin
      state_q <= INIT;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_cv32e40x_bpred_seq.sv
// tb_cv32e40x_bpred_seq: randomized and directed checks of the sequencer against a queue-based model
module tb_cv32e40x_bpred_seq;
  localparam int N = 16;
  localparam int D = 2;
`ifdef CV32E40X_BPRED_ALLOC_EN
  localparam bit ALLOC = 1'b1;
`else
  localparam bit ALLOC = 1'b0;
`endif
  typedef struct {int idx; bit hit; int ctr; bit taken;} upd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  cv32e40x_bpred_seq_if #(.IDX_W(4)) bus();
  cv32e40x_bpred_seq #(.BTB_ENTRIES(N), .IDX_W(4), .UPD_DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, got, want, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  bit   known = 0;
  bit   m_init, m_flush;
  int   pos;
  upd_t q[$];
  always @(negedge clk) begin
    int e_we, e_widx, e_wv, e_wc, e_gnt, e_rdy, e_ack;
    bit walking, pop;
    upd_t h;
    if (rst) begin
      known = 1; m_init = 1; m_flush = 0; pos = 0; q.delete();
    end else if (known) begin
      walking = m_init || m_flush;
      pop = 0; e_we = 0; e_widx = 0; e_wv = 0; e_wc = 0;
      if (walking) begin
        e_we = 1; e_widx = pos; e_gnt = 0; e_rdy = int'(m_flush);
        e_ack = int'(pos == N-1 && (m_flush || bus.flush_req_i));
      end else begin
        e_rdy = int'(q.size() < D);
        e_ack = 0;
        e_gnt = int'(!bus.flush_req_i && bus.lookup_req_i && q.size() < D);
        pop = !bus.flush_req_i && q.size() > 0 && (q.size() == D || !bus.lookup_req_i);
        if (pop) begin
          h = q[0];
          if (h.hit) begin
            e_we = 1; e_widx = h.idx; e_wv = 1;
            e_wc = h.taken ? (h.ctr == 3 ? 3 : h.ctr + 1) : (h.ctr == 0 ? 0 : h.ctr - 1);
          end else if (h.taken && ALLOC) begin
            e_we = 1; e_widx = h.idx; e_wv = 1; e_wc = 2;
          end
        end
      end
      chk("arr_we", bus.arr_we_o, e_we);
      if (e_we == 1) begin
        chk("arr_widx", bus.arr_widx_o, e_widx);
        chk("arr_wvalid", bus.arr_wvalid_o, e_wv);
        chk("arr_wctr", bus.arr_wctr_o, e_wc);
      end
      chk("lookup_gnt", bus.lookup_gnt_o, e_gnt);
      chk("upd_ready", bus.upd_ready_o, e_rdy);
      chk("flush_ack", bus.flush_ack_o, e_ack);
      chk("busy", bus.busy_o, int'(walking));
      if (walking) begin
        if (pos == N-1) begin m_init = 0; m_flush = 0; end
        pos = (pos + 1) % N;
      end else begin
        if (pop) void'(q.pop_front());
        if (bus.upd_valid_i && e_rdy == 1)
          q.push_back('{int'(bus.upd_idx_i), bus.upd_hit_i, int'(bus.upd_ctr_i), bus.upd_taken_i});
        if (bus.flush_req_i) begin q.delete(); m_flush = 1; pos = 0; end
      end
    end
  end
  task automatic upd(input int idx, input bit hit, input int ctr, input bit taken);
    bus.upd_valid_i = 1; bus.upd_idx_i = 4'(idx); bus.upd_hit_i = hit;
    bus.upd_ctr_i = 2'(ctr); bus.upd_taken_i = taken;
  endtask
  initial begin
    logic a;
    bus.lookup_req_i = 0; bus.lookup_idx_i = 0; bus.upd_valid_i = 0; bus.upd_idx_i = 0;
    bus.upd_hit_i = 0; bus.upd_ctr_i = 0; bus.upd_taken_i = 0; bus.flush_req_i = 0;
    cyc(); cyc();
    rst = 0; bus.lookup_req_i = 1;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("init_we", bus.arr_we_o, 1); chk("init_widx", bus.arr_widx_o, i);
      chk("init_wvalid", bus.arr_wvalid_o, 0); chk("init_busy", bus.busy_o, 1);
      chk("init_gnt", bus.lookup_gnt_o, 0);
      cyc();
    end
    @(negedge clk);
    chk("first_busy", bus.busy_o, 0); chk("first_gnt", bus.lookup_gnt_o, 1);
    cyc();
    bus.lookup_req_i = 0; upd(5, 1, 3, 1);
    @(negedge clk); chk("upd_ready", bus.upd_ready_o, 1);
    cyc();
    upd(5, 1, 0, 0);
    @(negedge clk);
    chk("sat_hi_we", bus.arr_we_o, 1); chk("sat_hi_idx", bus.arr_widx_o, 5);
    chk("sat_hi_v", bus.arr_wvalid_o, 1); chk("sat_hi_ctr", bus.arr_wctr_o, 3);
    cyc();
    bus.upd_valid_i = 0;
    @(negedge clk); chk("sat_lo_we", bus.arr_we_o, 1); chk("sat_lo_ctr", bus.arr_wctr_o, 0);
    cyc();
    bus.lookup_req_i = 1; upd(3, 1, 1, 1);
    @(negedge clk); chk("arb0_gnt", bus.lookup_gnt_o, 1); chk("arb0_we", bus.arr_we_o, 0);
    cyc();
    upd(4, 1, 1, 1);
    @(negedge clk); chk("arb1_gnt", bus.lookup_gnt_o, 1); chk("arb1_we", bus.arr_we_o, 0);
    cyc();
    bus.upd_valid_i = 0;
    @(negedge clk);
    chk("arb2_gnt", bus.lookup_gnt_o, 0); chk("arb2_ready", bus.upd_ready_o, 0);
    chk("arb2_we", bus.arr_we_o, 1); chk("arb2_idx", bus.arr_widx_o, 3); chk("arb2_ctr", bus.arr_wctr_o, 2);
    cyc();
    @(negedge clk); chk("arb3_gnt", bus.lookup_gnt_o, 1);
    cyc();
    bus.lookup_req_i = 0;
    @(negedge clk); chk("arb4_idx", bus.arr_widx_o, 4);
    cyc();
    upd(9, 0, 0, 1);
    cyc();
    bus.upd_valid_i = 0;
    @(negedge clk);
    chk("miss_we", bus.arr_we_o, int'(ALLOC));
    if (ALLOC) begin chk("miss_idx", bus.arr_widx_o, 9); chk("miss_ctr", bus.arr_wctr_o, 2); end
    cyc();
    bus.lookup_req_i = 1; upd(7, 1, 1, 1);
    cyc();
    bus.upd_valid_i = 0; bus.flush_req_i = 1;
    @(negedge clk); chk("flreq_gnt", bus.lookup_gnt_o, 0); chk("flreq_we", bus.arr_we_o, 0);
    cyc();
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("fl_widx", bus.arr_widx_o, i); chk("fl_wvalid", bus.arr_wvalid_o, 0);
      chk("fl_ack", bus.flush_ack_o, int'(i == N-1));
      cyc();
    end
    bus.flush_req_i = 0; bus.lookup_req_i = 0;
    @(negedge clk); chk("fl_drop_we", bus.arr_we_o, 0); chk("fl_done_busy", bus.busy_o, 0);
    cyc();
    bus.flush_req_i = 1;
    for (int i = 0; i < 8; i++) cyc();
    #2 chk("rstfl_idx", bus.arr_widx_o, 7);
    rst = 1; bus.flush_req_i = 0;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rstfl_init_idx", bus.arr_widx_o, 0); chk("rstfl_busy", bus.busy_o, 1); chk("rstfl_ack", bus.flush_ack_o, 0);
    cyc();
    for (int i = 0; i < N; i++) cyc();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      a = bus.flush_ack_o;
      cyc();
      rst = $urandom_range(0, 799) == 0;
      if (a) bus.flush_req_i = 0;
      else if (!bus.flush_req_i && $urandom_range(0, 149) == 0) bus.flush_req_i = 1;
      bus.lookup_req_i = 1'($urandom_range(0, 1));
      bus.lookup_idx_i = 4'($urandom_range(0, 15));
      bus.upd_valid_i = 1'($urandom_range(0, 1));
      bus.upd_idx_i = 4'($urandom_range(0, 15));
      bus.upd_hit_i = $urandom_range(0, 9) < 7;
      bus.upd_ctr_i = 2'($urandom_range(0, 3));
      bus.upd_taken_i = 1'($urandom_range(0, 1));
    end
    rst = 0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
